alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand/result width (min 4, power of two).
REQ-002 SHALL have parameter SHW, default 4, giving the shift-amount width (= log2 WIDTH).
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request; sampled only when the block is ready (IDLE or DONE).
REQ-006 SHALL have port sel  in  4  opcode: 0 pass a, 1 and, 2 or, 3 xor, 4 not a, 5 add, 6 sub, 7 inc a, 8 dec a, 9 zero, 10 shl, 11 shr, 12 mul.
REQ-007 SHALL have ports a, b  in  WIDTH  operands, captured on accepted start.
REQ-008 SHALL have port c  out  WIDTH  registered result.
REQ-009 SHALL have port busy  out  1  high while a multi-cycle op runs (RUN state).
REQ-010 SHALL have port done  out  1  one-cycle pulse when c and flags become valid.
REQ-011 SHALL have ports zf, cf, nf, vf  out  1 each  zero/carry/negative/overflow flags.
REQ-012 SHALL have port illegal  out  1  set with done when sel was unsupported.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; start is accepted in IDLE or DONE and ignored in RUN.
REQ-014 Ops 0-9 and 13-15 SHALL go accepted-start -> DONE next cycle (latency 1: done high the cycle after start).
REQ-015 shl/shr SHALL shift logically by n = b[SHW-1:0], one bit per cycle in RUN; done n+1 cycles after start; n=0 goes straight to DONE.
REQ-016 mul SHALL be unsigned shift-add, one bit per cycle, WIDTH cycles in RUN; done WIDTH+1 cycles after start; c = low WIDTH bits of product.
REQ-017 Operands and sel SHALL be latched at accept; input changes during RUN have no effect.
REQ-018 c and flags SHALL update only in the cycle done rises and SHALL hold until the next done.
REQ-019 zf = (c==0); nf = c[WIDTH-1], for all legal ops.
REQ-020 cf: add carry-out; sub borrow (a<b unsigned); inc carry (a all ones); dec borrow (a==0); shl/shr last bit shifted out (0 if n=0); mul 1 if product upper half nonzero; else 0.
REQ-021 vf: two's-complement overflow for add, sub, inc, dec; 0 otherwise.
REQ-022 sel 13-15 SHALL give c=0, all flags 0, illegal=1; illegal SHALL be 0 for every legal op.
REQ-023 DONE with start high SHALL accept the new op that cycle (back-to-back); otherwise DONE -> IDLE.
REQ-024 done SHALL never be high in two consecutive cycles except for back-to-back single-cycle ops.

Reset
REQ-025 reset low at a rising edge SHALL force IDLE, c=0, busy=0, done=0, zf=cf=nf=vf=0, illegal=0, clearing internal counters.
REQ-026 reset during RUN SHALL abort the op with no done pulse; start is ignored while reset is low.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN defined: mul (sel 12) implemented per REQ-016.
REQ-028 ALU_SEQ_MUL_EN undefined: no multiplier logic; sel 12 treated as illegal per REQ-022 (latency 1).

Verification (WIDTH=16)
REQ-029 add a=0xFFFF b=0x0001 -> done 1 cycle later, c=0x0000, zf=1, cf=1, vf=0, nf=0.
REQ-030 sub a=0x8000 b=0x0001 -> c=0x7FFF, vf=1, cf=0, nf=0; then dec a=0x0000 back-to-back -> c=0xFFFF, cf=1, nf=1.
REQ-031 shl a=0x8001 b=0x0004 -> busy 4 cycles, done 5 cycles after start, c=0x0010, cf=0; start pulsed during busy ignored.
REQ-032 mul a=0x0100 b=0x0100 (macro on) -> done 17 cycles after start, c=0x0000, zf=1, cf=1; macro off -> done after 1, illegal=1, c=0.
REQ-033 sel=14 -> c=0, illegal=1; next op pass a=0x1234 -> c=0x1234, illegal=0.
REQ-034 reset low 5 cycles into mul -> no done, busy=0, c=0 next cycle; new add after reset completes correctly.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arithmetic ops and multi-cycle shift/multiply
// Build option: define ALU_SEQ_MUL_EN to implement the shift-add multiplier on sel 12;
//   when it is undefined sel 12 completes in one cycle as an illegal opcode.
// Ports:
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   start, sel, a, b request, opcode and operands, sampled in IDLE or DONE
//   c                registered result, held until the next done
//   busy             high while a shift or multiply runs
//   done             one-cycle pulse when c and the flags are updated
//   zf, cf, nf, vf   zero / carry / negative / overflow flags
//   illegal          set with done for an unsupported opcode
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic             zf,
  output logic             cf,
  output logic             nf,
  output logic             vf,
  output logic             illegal
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] OP_SHL = 4'd10;
  localparam logic [3:0] OP_SHR = 4'd11;
  localparam logic [3:0] OP_MUL = 4'd12;
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [SHW:0] CNT_LAST = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0] MUL_CNT = (SHW + 1)'(WIDTH);
  logic [1:0]       state;
  logic [3:0]       op;
  logic [WIDTH-1:0] acc;
  logic [SHW:0]     cnt;
  logic             accept;
  logic             shift_op;
  logic             is_mul;
  logic             multi;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] ic;
  logic             icf;
  logic             ivf;
  logic             ill;
  logic [WIDTH-1:0] sh_acc;
  logic             sh_out;
  logic [WIDTH-1:0] run_acc;
  logic [WIDTH-1:0] run_c;
  logic             run_cf;
  assign accept   = start && (state == IDLE || state == DONE);
  assign shift_op = sel == OP_SHL || sel == OP_SHR;
  assign busy     = state == RUN;
`ifdef ALU_SEQ_MUL_EN
  // Multiplier: acc holds the running upper half, lo the multiplier bits that
  // are consumed LSB first and replaced by the finished low product bits.
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   msum;
  assign is_mul  = sel == OP_MUL;
  assign msum    = {1'b0, acc} + (lo[0] ? {1'b0, ra} : '0);
  assign run_acc = op == OP_MUL ? msum[WIDTH:1] : sh_acc;
  assign run_c   = op == OP_MUL ? {msum[0], lo[WIDTH-1:1]} : sh_acc;
  assign run_cf  = op == OP_MUL ? |msum[WIDTH:1] : sh_out;
`else
  assign is_mul  = 1'b0;
  assign run_acc = sh_acc;
  assign run_c   = sh_acc;
  assign run_cf  = sh_out;
`endif
  // A zero shift amount completes like any single-cycle op.
  assign multi  = is_mul || (shift_op && b[SHW-1:0] != '0);
  assign sh_acc = op == OP_SHL ? acc << 1 : acc >> 1;
  assign sh_out = op == OP_SHL ? acc[WIDTH-1] : acc[0];
  // Single-cycle results; borrow/carry come from the zero-extended top bit.
  always_comb begin
    ext = '0;
    ic  = '0;
    icf = 1'b0;
    ivf = 1'b0;
    ill = 1'b0;
    case (sel)
      4'd0: ic = a;
      4'd1: ic = a & b;
      4'd2: ic = a | b;
      4'd3: ic = a ^ b;
      4'd4: ic = ~a;
      4'd5: begin
        ext = {1'b0, a} + {1'b0, b};
        ic  = ext[WIDTH-1:0];
        icf = ext[WIDTH];
        ivf = (a[WIDTH-1] == b[WIDTH-1]) && (ic[WIDTH-1] != a[WIDTH-1]);
      end
      4'd6: begin
        ext = {1'b0, a} - {1'b0, b};
        ic  = ext[WIDTH-1:0];
        icf = ext[WIDTH];
        ivf = (a[WIDTH-1] != b[WIDTH-1]) && (ic[WIDTH-1] != a[WIDTH-1]);
      end
      4'd7: begin
        ext = {1'b0, a} + ONE;
        ic  = ext[WIDTH-1:0];
        icf = ext[WIDTH];
        ivf = !a[WIDTH-1] && ic[WIDTH-1];
      end
      4'd8: begin
        ext = {1'b0, a} - ONE;
        ic  = ext[WIDTH-1:0];
        icf = ext[WIDTH];
        ivf = a[WIDTH-1] && !ic[WIDTH-1];
      end
      4'd9:  ic = '0;
      4'd10: ic = a;
      4'd11: ic = a;
      default: ill = 1'b1;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      op      <= '0;
      acc     <= '0;
      cnt     <= '0;
      c       <= '0;
      done    <= 1'b0;
      zf      <= 1'b0;
      cf      <= 1'b0;
      nf      <= 1'b0;
      vf      <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      ra      <= '0;
      lo      <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        op <= sel;
        if (multi) begin
          state <= RUN;
          acc   <= is_mul ? '0 : a;
          cnt   <= is_mul ? MUL_CNT : {1'b0, b[SHW-1:0]};
`ifdef ALU_SEQ_MUL_EN
          ra    <= a;
          lo    <= b;
`endif
        end else begin
          state   <= DONE;
          done    <= 1'b1;
          c       <= ic;
          zf      <= !ill && ic == '0;
          cf      <= icf;
          nf      <= ic[WIDTH-1];
          vf      <= ivf;
          illegal <= ill;
        end
      end else if (state == RUN) begin
        acc <= run_acc;
        cnt <= cnt - 1'b1;
`ifdef ALU_SEQ_MUL_EN
        lo  <= {msum[0], lo[WIDTH-1:1]};
`endif
        if (cnt == CNT_LAST) begin
          state   <= DONE;
          done    <= 1'b1;
          c       <= run_c;
          zf      <= run_c == '0;
          cf      <= run_cf;
          nf      <= run_c[WIDTH-1];
          vf      <= 1'b0;
          illegal <= 1'b0;
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16) against an arithmetic reference model
module tb_alu_seq;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  sel = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] c;
  logic        busy, done, zf, cf, nf, vf, illegal;
  int n_cmp = 0;
  int n_err = 0;

  alu_seq dut (
    .clock(clock), .reset(reset), .start(start), .sel(sel), .a(a), .b(b),
    .c(c), .busy(busy), .done(done), .zf(zf), .cf(cf), .nf(nf), .vf(vf),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Expected result, flags {zf,cf,nf,vf,illegal} and done latency from plain arithmetic.
  function automatic void model(input logic [3:0] s, input logic [15:0] x, input logic [15:0] y,
                                output logic [15:0] ec, output logic [4:0] ef, output int lat);
    int sx, sy, r, n;
    longint u;
    logic ez, ecf, en, ev, eil;
    sx = int'($signed(x));
    sy = int'($signed(y));
    n = int'(y[3:0]);
    u = 0;
    ec = '0; ecf = 1'b0; ev = 1'b0; eil = 1'b0; lat = 1;
    case (s)
      4'd0: ec = x;
      4'd1: ec = x & y;
      4'd2: ec = x | y;
      4'd3: ec = x ^ y;
      4'd4: ec = ~x;
      4'd5: begin
        u = longint'(x) + longint'(y);
        ec = u[15:0]; ecf = u > 65535;
        r = sx + sy; ev = r > 32767 || r < -32768;
      end
      4'd6: begin
        ec = x - y; ecf = x < y;
        r = sx - sy; ev = r > 32767 || r < -32768;
      end
      4'd7: begin ec = x + 16'd1; ecf = x == 16'hFFFF; ev = sx == 32767; end
      4'd8: begin ec = x - 16'd1; ecf = x == 16'h0000; ev = sx == -32768; end
      4'd9: ec = '0;
      4'd10: begin
        u = longint'(x) << n;
        ec = u[15:0]; ecf = n != 0 && u[16]; lat = n + 1;
      end
      4'd11: begin
        ec = x >> n; ecf = n != 0 ? x[n-1] : 1'b0; lat = n + 1;
      end
`ifdef ALU_SEQ_MUL_EN
      4'd12: begin
        u = longint'(x) * longint'(y);
        ec = u[15:0]; ecf = u[31:16] != 0; lat = 17;
      end
`endif
      default: eil = 1'b1;
    endcase
    ez = !eil && ec == 16'h0000;
    en = ec[15];
    ef = {ez, ecf, en, ev, eil};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 16'h0000;
      1: pick = 16'hFFFF;
      2: pick = 16'h8000;
      3: pick = 16'h7FFF;
      default: pick = 16'($urandom);
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, optionally poke start while busy,
  // then check latency, busy length, result, flags and (if hold) the quiet cycle after.
  task automatic run_op(input string tag, input logic [3:0] s, input logic [15:0] x,
                        input logic [15:0] y, input bit poke, input bit hold);
    logic [15:0] ec;
    logic [4:0]  ef;
    int lat, cyc, bsy;
    model(s, x, y, ec, ef, lat);
    @(negedge clock);
    start = 1'b1; sel = s; a = x; b = y;
    @(posedge clock); #1;
    start = 1'b0; sel = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    cyc = 1; bsy = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bsy++;
      start = poke && cyc == 1 && busy === 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    n_cmp++;
    if (cyc !== lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat); end
    n_cmp++;
    if (bsy !== lat - 1) begin n_err++; $display("FAIL %s busy cycles: got %0d want %0d", tag, bsy, lat - 1); end
    n_cmp++;
    if (c !== ec) begin n_err++; $display("FAIL %s c: got %h want %h", tag, c, ec); end
    n_cmp++;
    if ({zf, cf, nf, vf, illegal} !== ef)
      begin n_err++; $display("FAIL %s flags zcnvi: got %b want %b", tag, {zf, cf, nf, vf, illegal}, ef); end
    if (hold) begin
      @(posedge clock); #1;
      n_cmp++;
      if (done !== 1'b0 || c !== ec)
        begin n_err++; $display("FAIL %s hold: done %b c %h want done 0 c %h", tag, done, c, ec); end
    end
  endtask

  task automatic test_reset();
    start = 1'b1; sel = 4'd5; a = 16'h1234; b = 16'h4321;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if ({c, busy, done, zf, cf, nf, vf, illegal} !== 23'd0)
      begin n_err++; $display("FAIL reset state: got %h want 0", {c, busy, done, zf, cf, nf, vf, illegal}); end
    @(negedge clock);
    start = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL reset release idle: done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_directed();
    run_op("add_wrap", 4'd5, 16'hFFFF, 16'h0001, 0, 1);
    run_op("shl_4", 4'd10, 16'h8001, 16'h0004, 1, 1);
    run_op("shr_0", 4'd11, 16'h8001, 16'h0000, 0, 1);
    run_op("shr_15", 4'd11, 16'h8001, 16'h000F, 1, 1);
    run_op("mul_100", 4'd12, 16'h0100, 16'h0100, 1, 1);
    run_op("mul_small", 4'd12, 16'h0123, 16'h0045, 0, 1);
    run_op("inc_7fff", 4'd7, 16'h7FFF, 16'h0000, 0, 1);
    run_op("illegal_14", 4'd14, 16'h5555, 16'hAAAA, 0, 1);
    run_op("pass_after_ill", 4'd0, 16'h1234, 16'h0000, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_op("sub_ovf", 4'd6, 16'h8000, 16'h0001, 0, 0);
    start = 1'b1; sel = 4'd8; a = 16'h0000; b = 16'($urandom);
    @(posedge clock); #1;
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || c !== 16'hFFFF)
      begin n_err++; $display("FAIL b2b dec: done %b c %h want 1 ffff", done, c); end
    n_cmp++;
    if ({zf, cf, nf, vf, illegal} !== 5'b01100)
      begin n_err++; $display("FAIL b2b dec flags: got %b want 01100", {zf, cf, nf, vf, illegal}); end
    @(posedge clock); #1;
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL b2b done drop: got %b want 0", done); end
  endtask

  task automatic test_abort();
    int dn;
    logic [15:0] ec;
    logic [4:0]  ef;
    int lat;
    run_op("pre_abort", 4'd0, 16'hBEEF, 16'h0000, 0, 1);
`ifdef ALU_SEQ_MUL_EN
    model(4'd12, 16'h0100, 16'h0100, ec, ef, lat);
    @(negedge clock); start = 1'b1; sel = 4'd12; a = 16'h0100; b = 16'h0100;
`else
    model(4'd10, 16'h0100, 16'h000F, ec, ef, lat);
    @(negedge clock); start = 1'b1; sel = 4'd10; a = 16'h0100; b = 16'h000F;
`endif
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin n_err++; $display("FAIL abort pre busy: busy %b done %b want 1 0 (op latency %0d)", busy, done, lat); end
    @(negedge clock); reset = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if ({c, busy, done, zf, cf, nf, vf, illegal} !== 23'd0)
      begin n_err++; $display("FAIL abort reset: got %h want 0", {c, busy, done, zf, cf, nf, vf, illegal}); end
    @(negedge clock); reset = 1'b1; start = 1'b0;
    dn = 0;
    repeat (20) begin @(posedge clock); #1; if (done === 1'b1) dn++; end
    n_cmp++;
    if (dn !== 0) begin n_err++; $display("FAIL abort no done: got %0d pulses want 0", dn); end
    run_op("add_after_abort", 4'd5, 16'h1111, 16'h2222, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_op("random", 4'($urandom_range(0, 15)), pick(), pick(), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
